tile_lane_engine: RTL and testbench

Parametrised scrolling-tile game core for the VGA piano-tiles display. It holds a NUM_ROWS × NUM_LANES playfield, advances it once per video frame at a ramping speed, judges player key presses against the bottom row, and keeps score. It also classifies every pixel for the colour mapper. It replaces the fixed 5-lane/4-row tile logic and runs entirely in the pixel_clk domain; vs is synchronised internally.

---
 rtl/tile_pkg.sv | 32 +++
 rtl/tile_lfsr.sv | 20 ++
 rtl/tile_lane_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_tile_lane_engine.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and constants for the scrolling-tile game core.
package tile_pkg;

  // Game flow: waiting for the first key, scrolling, frozen after a mistake.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } game_state_t;

  // Pixel classes handed to the colour mapper.
  typedef enum logic [1:0] {
    PX_WHITE  = 2'd0,
    PX_BLACK  = 2'd1,
    PX_HIT    = 2'd2,
    PX_BORDER = 2'd3
  } px_class_t;

  // Lane index field is sized for the largest supported lane count (8).
  localparam int LANE_IDX_W = 3;

  // One playfield row: which lane holds the black tile, and whether it was hit.
  typedef struct packed {
    logic [LANE_IDX_W-1:0] lane;
    logic                  hit;
  } row_t;

  // 8-bit Fibonacci LFSR, polynomial taps 8,6,5,4 (bit indices 7,5,4,3).
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/tile_lfsr.sv
// 8-bit Fibonacci LFSR that picks the lane of each new incoming tile.
module tile_lfsr
  import tile_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       Reset,
  input  logic       step,
  output logic [7:0] value
);

  // Shift left, feeding the XOR of the tap bits into bit 0, only when stepped.
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/tile_lane_engine.sv
// Scrolling-tile game core: playfield, frame-rate scrolling with speed ramp,
// key judging against the bottom row, scoring and per-pixel classification.
//
// Handshake: key_valid is a single-cycle strobe with no back-pressure; every
// cycle with key_valid high is judged exactly once, in that cycle, together
// with any frame tick that lands in the same cycle (key first, then tick).
module tile_lane_engine
  import tile_pkg::*;
#(
  parameter int NUM_LANES  = 5,
  parameter int NUM_ROWS   = 4,
  parameter int H_RES      = 640,
  parameter int ROW_H      = 120,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX  = 12,
  parameter int RAMP_ROWS  = 5,
  parameter int SCORE_W    = 12
) (
  input  logic                         pixel_clk,
  input  logic                         Reset,
  input  logic                         vs,
  input  logic                         key_valid,
  input  logic [$clog2(NUM_LANES)-1:0] key_lane,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  output logic [1:0]                   px_class,
  output logic [1:0]                   state,
  output logic [3:0]                   speed,
  output logic [SCORE_W-1:0]           score
);

  localparam int LANE_W = H_RES / NUM_LANES;
  localparam int RAMP_W = (RAMP_ROWS < 1) ? 1 : $clog2(RAMP_ROWS + 1);

  // Registered game state.
  game_state_t        state_q, state_d;
  row_t               rows_q [NUM_ROWS];
  row_t               rows_d [NUM_ROWS];
  row_t               incoming_q, incoming_d;
  logic [7:0]         offset_q, offset_d;
  logic [3:0]         speed_q, speed_d;
  logic [RAMP_W-1:0]  ramp_q, ramp_d;
  logic [SCORE_W-1:0] score_q, score_d;

  // Frame tick recovery.
  logic vs_s1, vs_s2, vs_s3;
  logic tick_q;

  // LFSR hookup.
  logic       lfsr_step;
  logic [7:0] lfsr_value;

  // Rule-evaluation helpers.
  logic               key_on_bottom;
  logic               bottom_hit;
  logic               key_fail;
  logic [8:0]         offset_sum;
  logic [RAMP_W-1:0]  ramp_next;
  logic [SCORE_W-1:0] score_inc;

  // Pixel classification helpers.
  logic [9:0]  draw_lane;
  logic [9:0]  lane_pos;
  logic [10:0] y_rel;
  logic [9:0]  row_idx;
  row_t        pick;
  logic        in_field;
  px_class_t   px_class_d, px_class_q;

  tile_lfsr u_lfsr (
    .pixel_clk (pixel_clk),
    .Reset     (Reset),
    .step      (lfsr_step),
    .value     (lfsr_value)
  );

  assign key_on_bottom = (8'(key_lane) == 8'(rows_q[NUM_ROWS-1].lane));
  assign score_inc     = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

  // Synchronise vs and register a one-cycle tick on its rising edge.
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      vs_s1  <= 1'b0;
      vs_s2  <= 1'b0;
      vs_s3  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      vs_s1  <= vs;
      vs_s2  <= vs_s1;
      vs_s3  <= vs_s2;
      tick_q <= vs_s2 & ~vs_s3;
    end
  end

  // Game state register; the bottom row starts on lane 0 and lanes climb upward.
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_ROWS; i++) begin
        rows_q[i].lane <= LANE_IDX_W'((NUM_ROWS - 1 - i) % NUM_LANES);
        rows_q[i].hit  <= 1'b0;
      end
      incoming_q.lane <= LANE_IDX_W'(NUM_ROWS % NUM_LANES);
      incoming_q.hit  <= 1'b0;
      offset_q        <= 8'd0;
      speed_q         <= 4'(SPEED_INIT);
      ramp_q          <= '0;
      score_q         <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      incoming_q <= incoming_d;
      offset_q   <= offset_d;
      speed_q    <= speed_d;
      ramp_q     <= ramp_d;
      score_q    <= score_d;
    end
  end

  // Game rules: judge the key first, then let the frame tick scroll the field.
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    incoming_d = incoming_q;
    offset_d   = offset_q;
    speed_d    = speed_q;
    ramp_d     = ramp_q;
    score_d    = score_q;
    lfsr_step  = 1'b0;
    bottom_hit = rows_q[NUM_ROWS-1].hit;
    key_fail   = 1'b0;
    offset_sum = {1'b0, offset_q} + {5'd0, speed_q};
    ramp_next  = ramp_q + RAMP_W'(1);

    case (state_q)
      IDLE: begin
        // Only the correct first key starts the game; anything else is ignored.
        if (key_valid && key_on_bottom && !rows_q[NUM_ROWS-1].hit) begin
          state_d                  = RUN;
          rows_d[NUM_ROWS-1].hit   = 1'b1;
          score_d                  = score_inc;
        end
      end

      RUN: begin
        // Once the bottom row is hit, further keys are ignored until it scrolls out.
        if (key_valid && !rows_q[NUM_ROWS-1].hit) begin
          if (key_on_bottom) begin
            rows_d[NUM_ROWS-1].hit = 1'b1;
            score_d                = score_inc;
            bottom_hit             = 1'b1;
          end else begin
            key_fail = 1'b1;
          end
        end

        if (key_fail) begin
          state_d = FAIL;
        end else if (tick_q) begin
          if (offset_sum >= 9'(ROW_H)) begin
            if (!bottom_hit) begin
              // An unhit tile would leave the screen: freeze the field as is.
              state_d = FAIL;
            end else begin
              // Keep the residual so scrolling stays smooth across the wrap.
              offset_d = 8'(offset_sum - 9'(ROW_H));
              for (int i = NUM_ROWS - 1; i > 0; i--) begin
                rows_d[i] = rows_q[i-1];
              end
              rows_d[0]       = incoming_q;
              incoming_d.lane = LANE_IDX_W'(lfsr_value % 8'(NUM_LANES));
              incoming_d.hit  = 1'b0;
              lfsr_step       = 1'b1;
              if (ramp_next == RAMP_W'(RAMP_ROWS)) begin
                ramp_d = '0;
                if (speed_q < 4'(SPEED_MAX)) begin
                  speed_d = speed_q + 4'd1;
                end
              end else begin
                ramp_d = ramp_next;
              end
            end
          end else begin
            offset_d = offset_sum[7:0];
          end
        end
      end

      default: begin
        // FAIL holds everything until Reset.
      end
    endcase
  end

  // Classify the current pixel against the (possibly frozen) playfield.
  always_comb begin
    draw_lane = DrawX / 10'(LANE_W);
    lane_pos  = DrawX % 10'(LANE_W);
    y_rel     = {1'b0, DrawY} - {3'b000, offset_q};
    row_idx   = y_rel[9:0] / 10'(ROW_H);
    pick      = '0;
    in_field  = 1'b0;

    if (y_rel[10]) begin
      // Above row 0: the partially visible incoming row.
      pick     = incoming_q;
      in_field = 1'b1;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (row_idx == 10'(r)) begin
          pick     = rows_q[r];
          in_field = 1'b1;
        end
      end
    end

    px_class_d = PX_WHITE;
    if (lane_pos == 10'd0 || lane_pos == 10'(LANE_W - 1)) begin
      px_class_d = PX_BORDER;
    end else if (in_field && draw_lane == 10'(pick.lane)) begin
      px_class_d = pick.hit ? PX_HIT : PX_BLACK;
    end
  end

  // One-cycle pixel pipeline register.
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      px_class_q <= PX_WHITE;
    end else begin
      px_class_q <= px_class_d;
    end
  end

  assign px_class = px_class_q;
  assign state    = state_q;
  assign speed    = speed_q;
  assign score    = score_q;

endmodule

// File: tb/tb_tile_lane_engine.sv
// Bench for tile_lane_engine: game reference model, status and pixel scoreboards.
module tb_tile_lane_engine;

  localparam int NL = 5;
  localparam int NR = 4;
  localparam int HR = 640;
  localparam int RH = 120;
  localparam int SI = 7;
  localparam int SM = 10;
  localparam int RR = 2;
  localparam int SW = 4;
  localparam int KW = $clog2(NL);
  localparam int W  = 2 + 4 + SW;
  localparam int LW = HR / NL;

  logic          pixel_clk = 1'b0;
  logic          Reset     = 1'b1;
  logic          vs        = 1'b0;
  logic          key_valid = 1'b0;
  logic [KW-1:0] key_lane  = '0;
  logic [9:0]    DrawX     = '0;
  logic [9:0]    DrawY     = '0;
  logic [1:0]    px_class;
  logic [1:0]    state;
  logic [3:0]    speed;
  logic [SW-1:0] score;

  tile_lane_engine #(
    .NUM_LANES  (NL),
    .NUM_ROWS   (NR),
    .H_RES      (HR),
    .ROW_H      (RH),
    .SPEED_INIT (SI),
    .SPEED_MAX  (SM),
    .RAMP_ROWS  (RR),
    .SCORE_W    (SW)
  ) dut (
    .pixel_clk (pixel_clk),
    .Reset     (Reset),
    .vs        (vs),
    .key_valid (key_valid),
    .key_lane  (key_lane),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .px_class  (px_class),
    .state     (state),
    .speed     (speed),
    .score     (score)
  );

  // ---------------- clock ----------------
  always #5 pixel_clk = ~pixel_clk;

  // ---------------- reference model ----------------
  int m_state, m_speed, m_score, m_off, m_ramp, m_lfsr, m_inc_lane;
  int m_lane [NR];
  bit m_hit  [NR];

  function automatic void model_reset();
    m_state = 0; m_speed = SI; m_score = 0; m_off = 0; m_ramp = 0; m_lfsr = 'hA5;
    for (int i = 0; i < NR; i++) begin
      m_lane[i] = (NR - 1 - i) % NL;
      m_hit[i]  = 1'b0;
    end
    m_inc_lane = NR % NL;
  endfunction

  function automatic void score_up();
    if (m_score < (1 << SW) - 1) m_score++;
  endfunction

  function automatic void model_key(int lane);
    if (m_state == 0) begin
      if (lane == m_lane[NR-1]) begin
        m_state = 1; m_hit[NR-1] = 1'b1; score_up();
      end
    end else if (m_state == 1 && !m_hit[NR-1]) begin
      if (lane == m_lane[NR-1]) begin
        m_hit[NR-1] = 1'b1; score_up();
      end else begin
        m_state = 2;
      end
    end
  endfunction

  function automatic void model_tick();
    int n, fb;
    if (m_state != 1) return;
    n = m_off + m_speed;
    if (n < RH) begin
      m_off = n;
      return;
    end
    if (!m_hit[NR-1]) begin
      m_state = 2;
      return;
    end
    m_off = n - RH;
    for (int i = NR - 1; i > 0; i--) begin
      m_lane[i] = m_lane[i-1];
      m_hit[i]  = m_hit[i-1];
    end
    m_lane[0]  = m_inc_lane;
    m_hit[0]   = 1'b0;
    m_inc_lane = m_lfsr % NL;
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 255;
    m_ramp++;
    if (m_ramp == RR) begin
      m_ramp = 0;
      if (m_speed < SM) m_speed++;
    end
  endfunction

  function automatic int model_px(int x, int y);
    int yr, rl;
    bit rh, inf;
    yr = y - m_off; rl = 0; rh = 0; inf = 0;
    if (x % LW == 0 || x % LW == LW - 1) return 3;
    if (yr < 0) begin
      rl = m_inc_lane; inf = 1;
    end else if (yr / RH < NR) begin
      rl = m_lane[yr / RH]; rh = m_hit[yr / RH]; inf = 1;
    end
    if (inf && (x / LW) == rl) return rh ? 2 : 1;
    return 0;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   px_q[$];
  logic         chk_req  = 1'b0;
  logic         px_req   = 1'b0;
  logic         px_req_d = 1'b0;
  logic [W-1:0] mon_e;
  logic [1:0]   mon_p;
  int errors = 0;
  int checks = 0;

  always @(posedge pixel_clk) px_req_d <= px_req;

  always @(negedge pixel_clk) begin
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL status_underflow: no expected entry queued");
      end else begin
        mon_e = exp_q.pop_front();
        if ({state, speed, score} !== mon_e) begin
          errors++;
          $display("FAIL status got state=%0d speed=%0d score=%0d expected state=%0d speed=%0d score=%0d",
                   state, speed, score, mon_e[W-1 -: 2], mon_e[SW+3 -: 4], mon_e[SW-1:0]);
        end
      end
    end
    if (px_req_d) begin
      checks++;
      if (px_q.size() == 0) begin
        errors++;
        $display("FAIL px_underflow: no expected pixel queued");
      end else begin
        mon_p = px_q.pop_front();
        if (px_class !== mon_p) begin
          errors++;
          $display("FAIL px_class x=%0d y=%0d got %0d expected %0d (t=%0t)", DrawX, DrawY, px_class, mon_p, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_status();
    exp_q.push_back({2'(m_state), 4'(m_speed), SW'(m_score)});
    @(posedge pixel_clk); #1 chk_req = 1'b1;
    @(posedge pixel_clk); #1 chk_req = 1'b0;
  endtask

  task automatic px_pt(input int x, input int y);
    @(posedge pixel_clk); #1;
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    px_req = 1'b1;
    px_q.push_back(2'(model_px(x, y)));
  endtask

  task automatic px_end();
    @(posedge pixel_clk); #1 px_req = 1'b0;
  endtask

  task automatic px_burst(input int n);
    for (int i = 0; i < n; i++) px_pt($urandom_range(0, 799), $urandom_range(0, 524));
    px_end();
  endtask

  // Reset asserted asynchronously mid-cycle, optionally with vs high.
  task automatic do_reset();
    @(posedge pixel_clk); #1;
    vs        = 1'($urandom_range(0, 1));
    key_valid = 1'b0;
    #2 Reset  = 1'b1;
    DrawX  = 10'd128;
    DrawY  = 10'd0;
    px_req = 1'b1;
    px_q.push_back(2'd0);
    @(posedge pixel_clk); #1;
    px_req = 1'b0;
    vs     = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1 Reset = 1'b0;
    model_reset();
    check_status();
  endtask

  task automatic press(input int lane);
    @(posedge pixel_clk); #1;
    key_valid = 1'b1;
    key_lane  = KW'(lane);
    @(posedge pixel_clk); #1 key_valid = 1'b0;
    model_key(lane);
  endtask

  task automatic frame();
    @(posedge pixel_clk); #1 vs = 1'b1;
    repeat (5) @(posedge pixel_clk);
    #1 vs = 1'b0;
    repeat (4) @(posedge pixel_clk);
    model_tick();
  endtask

  // Key strobe placed exactly on the tick cycle (3 cycles after the vs rise).
  task automatic frame_with_key(input int lane);
    @(posedge pixel_clk); #1 vs = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    key_valid = 1'b1;
    key_lane  = KW'(lane);
    @(posedge pixel_clk); #1 key_valid = 1'b0;
    @(posedge pixel_clk); #1 vs = 1'b0;
    repeat (4) @(posedge pixel_clk);
    model_key(lane);
    model_tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, b, guard;
    do_reset();

    // Idle: a tick does nothing, a wrong key is ignored, the right key starts play.
    frame();        check_status();
    press(1);       check_status();
    press(0);       check_status();
    px_pt(128, 10); px_pt(200, 290); px_pt(50, 400); px_pt(200, 400);
    px_pt(639, 0);  px_pt(700, 100); px_pt(300, 500);
    px_end();

    // Wrap at speed 7: the 18th tick shifts with residual offset 6.
    repeat (17) begin frame(); check_status(); end
    px_pt(10, 3); px_pt(520, 50);
    px_end();
    frame(); check_status();
    px_pt(10, 3); px_pt(520, 50); px_pt(200, 376); px_pt(10, 5); px_pt(10, 6);
    px_end();
    press(1); check_status();
    px_pt(200, 376);
    px_end();

    // Scroll until a fresh unhit row reaches the bottom, then a wrong lane.
    guard = 0;
    while (m_hit[NR-1] && guard < 40) begin frame(); guard++; end
    check_status();
    press((m_lane[NR-1] + 2) % NL); check_status();
    press(m_lane[NR-1]);            check_status();
    frame();                        check_status();
    px_burst(6);

    // Randomised games: game 0 played perfectly, the rest sloppily.
    for (int g = 0; g < 6; g++) begin
      do_reset();
      px_burst(3);
      press(m_lane[NR-1]);
      check_status();
      for (int a = 0; a < ((g == 0) ? 400 : 300) && m_state != 2; a++) begin
        r = $urandom_range(0, 99);
        b = m_lane[NR-1];
        if (g == 0) begin
          if (!m_hit[NR-1] && m_off + m_speed >= RH) frame_with_key(b);
          else if (!m_hit[NR-1] && r < 10)           press(b);
          else if (m_hit[NR-1] && r < 8)             press($urandom_range(0, NL - 1));
          else                                        frame();
        end else begin
          if (r < 25)      press(b);
          else if (r < 29) press($urandom_range(0, NL - 1));
          else if (r < 36) frame_with_key((r < 34) ? b : $urandom_range(0, NL - 1));
          else             frame();
        end
        check_status();
        if (a % 8 == 7) px_burst(4);
      end
      press($urandom_range(0, NL - 1)); check_status();
      frame();                          check_status();
      px_burst(6);
    end

    repeat (4) @(posedge pixel_clk);
    checks++;
    if (exp_q.size() != 0 || px_q.size() != 0) begin
      errors++;
      $display("FAIL leftover expected entries status=%0d px=%0d required 0", exp_q.size(), px_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #900000;
    errors++;
    checks++;
    $display("FAIL timeout: run exceeded its time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
